// File: rtl/i2s_frame_buffer_if.sv
// I2S frame buffer bus: producer handshake, pop control and
// serializer-facing outputs bundled for the frame buffer.
interface i2s_frame_buffer_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8
);
    localparam int FW = WIDTH * CHANNELS;
    localparam int LW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_frame;
    logic          enable;
    logic          flush;
    logic [FW-1:0] out_frame;
    logic          out_valid;
    logic [LW-1:0] level;
    logic [15:0]   underrun_count;

    modport master (
        output in_valid,
        output in_frame,
        output enable,
        output flush,
        input  in_ready,
        input  out_frame,
        input  out_valid,
        input  level,
        input  underrun_count
    );

    modport slave (
        input  in_valid,
        input  in_frame,
        input  enable,
        input  flush,
        output in_ready,
        output out_frame,
        output out_valid,
        output level,
        output underrun_count
    );
endinterface

// File: rtl/i2s_frame_buffer.sv
// Frame FIFO between an audio producer and an I2S/TDM serializer;
// pops one frame per frame_clk edge and counts underruns.
module i2s_frame_buffer #(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 8,
    parameter int UNDERRUN_MODE = 0,
    parameter int LSB_FIRST     = 0
) (
    input  logic                 frame_clk,
    input  logic                 reset,
    i2s_frame_buffer_if.slave    bus
);
    localparam int FW = WIDTH * CHANNELS;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [LW-1:0] level_q;
    logic [FW-1:0] out_q;
    logic          out_valid_q;
    logic [15:0]   urun_q;
    logic [FW-1:0] head_frame;
    logic [FW-1:0] head_ordered;
    logic          full;
    logic          push;
    logic          pop;
    logic          underrun;

    assign full     = (level_q == LW'(DEPTH));
    assign push     = bus.in_valid && !full && !bus.flush;
    assign pop      = bus.enable && !bus.flush
                      && (level_q != '0);
    assign underrun = bus.enable && !bus.flush
                      && (level_q == '0);

    assign head_frame = mem[head];

    // Bit reversal is per sample; channel slots keep their place.
    generate
        if (LSB_FIRST != 0) begin : g_rev
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                    assign head_ordered[c*WIDTH + b] =
                        head_frame[c*WIDTH + WIDTH - 1 - b];
                end
            end
        end else begin : g_fwd
            assign head_ordered = head_frame;
        end
    endgenerate

    always_ff @(posedge frame_clk) begin
        if (push) begin
            mem[tail] <= bus.in_frame;
        end
    end

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            level_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            urun_q      <= '0;
        end else if (bus.flush) begin
            head        <= '0;
            tail        <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pop;
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head  <= head + AW'(1);
                out_q <= head_ordered;
            end
            if (underrun) begin
                if (UNDERRUN_MODE == 0) begin
                    out_q <= '0;
                end
                if (urun_q != 16'hFFFF) begin
                    urun_q <= urun_q + 16'd1;
                end
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.in_ready       = !full;
    assign bus.out_frame      = out_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.level          = level_q;
    assign bus.underrun_count = urun_q;
endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed bench for i2s_frame_buffer: zero-fill instance plus a
// repeat-last, LSB-first instance, both DEPTH 4.
module tb_i2s_frame_buffer;
    logic frame_clk = 1'b0;
    logic rst_a     = 1'b1;
    logic rst_b     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    always #5 frame_clk = ~frame_clk;

    i2s_frame_buffer_if #(.WIDTH(16), .CHANNELS(2), .DEPTH(4)) a_if ();
    i2s_frame_buffer_if #(.WIDTH(16), .CHANNELS(2), .DEPTH(4)) b_if ();

    i2s_frame_buffer #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(4),
        .UNDERRUN_MODE(0), .LSB_FIRST(0)
    ) dut_a (
        .frame_clk(frame_clk),
        .reset(rst_a),
        .bus(a_if)
    );

    i2s_frame_buffer #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(4),
        .UNDERRUN_MODE(1), .LSB_FIRST(1)
    ) dut_b (
        .frame_clk(frame_clk),
        .reset(rst_b),
        .bus(b_if)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [31:0] fr(input int i);
        return 32'hA0A0_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    initial begin
        a_if.in_valid = 0; a_if.in_frame = '0;
        a_if.enable   = 0; a_if.flush    = 0;
        b_if.in_valid = 0; b_if.in_frame = '0;
        b_if.enable   = 0; b_if.flush    = 0;
        #2;
        check("rst_frame", a_if.out_frame, 32'h0);
        check("rst_valid", 32'(a_if.out_valid), 32'h0);
        check("rst_level", 32'(a_if.level), 32'h0);
        check("rst_urun", 32'(a_if.underrun_count), 32'h0);
        check("rst_ready", 32'(a_if.in_ready), 32'h1);
        rst_a = 0; rst_b = 0;

        // Single frame round trip
        a_if.in_valid = 1;
        a_if.in_frame = {16'hABCD, 16'h1234};
        step();
        a_if.in_valid = 0;
        check("t1_level1", 32'(a_if.level), 32'd1);
        check("t1_novalid", 32'(a_if.out_valid), 32'h0);
        a_if.enable = 1;
        step();
        a_if.enable = 0;
        check("t1_frame", a_if.out_frame, 32'hABCD_1234);
        check("t1_valid", 32'(a_if.out_valid), 32'h1);
        check("t1_level0", 32'(a_if.level), 32'd0);
        step();
        check("t1_idle_valid", 32'(a_if.out_valid), 32'h0);
        check("t1_idle_hold", a_if.out_frame, 32'hABCD_1234);
        check("t1_idle_urun", 32'(a_if.underrun_count), 32'h0);

        // Fill to full, blocked push, drain in order
        for (int i = 0; i < 4; i++) begin
            a_if.in_valid = 1;
            a_if.in_frame = fr(i);
            step();
        end
        check("t2_full_level", 32'(a_if.level), 32'd4);
        check("t2_full_ready", 32'(a_if.in_ready), 32'h0);
        a_if.in_frame = 32'hDEAD_BEEF;
        step();
        check("t2_blocked", 32'(a_if.level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            a_if.in_valid = (i == 0);
            a_if.enable   = 1;
            step();
            check("t2_pop_frame", a_if.out_frame, fr(i));
            check("t2_pop_valid", 32'(a_if.out_valid), 32'h1);
            check("t2_pop_level", 32'(a_if.level), 32'(3 - i));
            check("t2_pop_ready", 32'(a_if.in_ready), 32'h1);
        end
        a_if.in_valid = 0;

        // Underrun on empty FIFO, zero-fill mode
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t3_frame", a_if.out_frame, 32'h0);
            check("t3_valid", 32'(a_if.out_valid), 32'h0);
            check("t3_urun", 32'(a_if.underrun_count), 32'(i));
        end
        a_if.enable = 0;

        // Streaming push+pop across pointer wrap
        a_if.in_valid = 1;
        a_if.in_frame = fr(20);
        step();
        for (int k = 1; k <= 10; k++) begin
            a_if.in_frame = fr(20 + k);
            a_if.enable   = 1;
            step();
            check("t4_frame", a_if.out_frame, fr(19 + k));
            check("t4_level", 32'(a_if.level), 32'd1);
        end
        a_if.in_valid = 0;
        step();
        a_if.enable = 0;
        check("t4_last", a_if.out_frame, fr(30));
        check("t4_empty", 32'(a_if.level), 32'd0);
        check("t4_urun", 32'(a_if.underrun_count), 32'd3);

        // Flush with three stored frames
        for (int i = 0; i < 3; i++) begin
            a_if.in_valid = 1;
            a_if.in_frame = fr(40 + i);
            step();
        end
        check("t5_level3", 32'(a_if.level), 32'd3);
        a_if.flush  = 1;
        a_if.enable = 1;
        step();
        a_if.flush    = 0;
        a_if.in_valid = 0;
        check("t5_level0", 32'(a_if.level), 32'd0);
        check("t5_valid", 32'(a_if.out_valid), 32'h0);
        check("t5_hold", a_if.out_frame, fr(30));
        check("t5_urun", 32'(a_if.underrun_count), 32'd3);
        step();
        a_if.enable = 0;
        check("t5_after_urun", 32'(a_if.underrun_count), 32'd4);
        check("t5_after_frame", a_if.out_frame, 32'h0);

        // LSB-first, repeat-last instance
        b_if.in_valid = 1;
        b_if.in_frame = {16'h1234, 16'h0001};
        step();
        b_if.in_valid = 0;
        b_if.enable   = 1;
        step();
        check("b_rev_frame", b_if.out_frame, 32'h2C48_8000);
        check("b_rev_valid", 32'(b_if.out_valid), 32'h1);
        for (int i = 1; i <= 2; i++) begin
            step();
            check("b_hold_frame", b_if.out_frame, 32'h2C48_8000);
            check("b_hold_valid", 32'(b_if.out_valid), 32'h0);
            check("b_hold_urun", 32'(b_if.underrun_count), 32'(i));
        end
        b_if.enable = 0;

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            a_if.in_valid = 1;
            a_if.in_frame = fr(50 + i);
            step();
        end
        a_if.in_valid = 0;
        a_if.enable   = 1;
        step();
        a_if.enable = 0;
        check("t6_pre_level", 32'(a_if.level), 32'd2);
        check("t6_pre_frame", a_if.out_frame, fr(50));
        #2;
        rst_a = 1;
        #1;
        check("t6_rst_frame", a_if.out_frame, 32'h0);
        check("t6_rst_valid", 32'(a_if.out_valid), 32'h0);
        check("t6_rst_level", 32'(a_if.level), 32'h0);
        check("t6_rst_urun", 32'(a_if.underrun_count), 32'h0);
        rst_a = 0;
        a_if.enable = 1;
        step();
        a_if.enable = 0;
        check("t6_post_urun", 32'(a_if.underrun_count), 32'd1);
        check("t6_post_valid", 32'(a_if.out_valid), 32'h0);
        check("t6_post_frame", a_if.out_frame, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_frame_buffer.md
I2S_FRAME_BUFFER -- requirements
Module: i2s_frame_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning bits per sample.
REQ-002 The block SHALL have parameter CHANNELS, default 2, meaning samples per frame (channel 0 = left, 1 = right, 2+ = TDM slots).
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning FIFO capacity in frames (power of 2, >= 2).
REQ-004 The block SHALL have parameter UNDERRUN_MODE, default 0, meaning frame emitted on underrun: 0 = all-zero frame, 1 = repeat last frame.
REQ-005 The block SHALL have parameter LSB_FIRST, default 0, meaning 1 = each sample bit-reversed on output.
REQ-006 The block SHALL have port frame_clk, input, 1 bit: sole clock, rising edge, one edge per audio frame.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: producer frame available.
REQ-009 The block SHALL have port in_ready, output, 1 bit: FIFO can accept a frame.
REQ-010 The block SHALL have port in_frame, input, CHANNELS*WIDTH bits: channel k in bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port enable, input, 1 bit: pop one frame per edge while high.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-013 The block SHALL have port out_frame, output, CHANNELS*WIDTH bits: registered frame for the serializer, same channel packing as in_frame.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_frame was loaded with FIFO data on the last edge.
REQ-015 The block SHALL have port level, output, $clog2(DEPTH+1) bits: frames stored.
REQ-016 The block SHALL have port underrun_count, output, 16 bits: saturating count of underrun events.

Function
REQ-017 in_ready SHALL be combinational: 1 iff level < DEPTH.
REQ-018 A push SHALL occur on an edge iff in_valid && in_ready && !flush; the frame is written at the tail, tail pointer +1 mod DEPTH.
REQ-019 A pop SHALL occur on an edge iff enable && !flush && level > 0 (level sampled before that edge's push); the head frame loads out_frame, out_valid <= 1, head pointer +1 mod DEPTH.
REQ-020 Pop latency SHALL be 1 edge; a frame pushed on edge N is poppable no earlier than edge N+1 (no bypass).
REQ-021 Underrun SHALL be enable && !flush && level == 0: out_frame <= 0 (UNDERRUN_MODE 0) or holds (mode 1), out_valid <= 0, underrun_count +1, saturating at 16'hFFFF.
REQ-022 With enable = 0 and no flush: out_frame holds, out_valid <= 0, no underrun counted.
REQ-023 A simultaneous push and pop SHALL leave level unchanged; a push alone SHALL raise level by 1; a pop alone SHALL lower it by 1.
REQ-024 When full (level == DEPTH), a push is blocked (in_ready = 0) even if a pop occurs on the same edge; in_ready re-asserts after the pop.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL preserve frame order and data.
REQ-026 flush SHALL override push and pop: pointers and level <= 0, out_valid <= 0, out_frame and underrun_count held, no underrun counted.
REQ-027 LSB_FIRST = 1 SHALL reverse bit order within each WIDTH-bit sample independently (bit i -> bit WIDTH-1-i); channel positions are unchanged.
REQ-028 Storage SHALL be exactly DEPTH x CHANNELS*WIDTH bits; no sample truncation or extension.

Reset
REQ-029 On reset assertion, independent of frame_clk: pointers 0, level 0, out_frame 0, out_valid 0, underrun_count 0; FIFO contents undefined and never emitted.
REQ-030 Reset asserted mid-operation SHALL discard all stored frames; after release, the first pop needs a new push.
REQ-031 On the first frame_clk edge after reset release, behaviour SHALL be normal.

Verification (WIDTH 16, CHANNELS 2, DEPTH 4 unless stated)
REQ-032 Push {L=16'h1234, R=16'hABCD}, then enable -> next edge out_frame = {16'hABCD,16'h1234}, out_valid = 1, level 1 -> 0.
REQ-033 Push 4 frames with enable low -> level = 4, in_ready = 0; 5th in_valid is not accepted; enable on 4 edges -> frames out in order, in_ready = 1 after the first pop.
REQ-034 Enable on an empty FIFO for 3 edges -> out_frame = 0, out_valid = 0, underrun_count = 3; repeat with UNDERRUN_MODE 1 -> out_frame = last popped frame.
REQ-035 Continuous push+pop for 10 edges (pointer wrap) -> level constant, output sequence equals input sequence delayed 1 edge.
REQ-036 LSB_FIRST = 1, push L = 16'h0001 -> out L = 16'h8000; flush with level 3 -> level 0, out_valid 0, out_frame held.
REQ-037 Reset asserted between edges with level 2 -> all outputs 0 immediately; the next enable counts an underrun.
